// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and index helper for the seven-segment scroll controller.
package seg7_pkg;

  localparam logic [7:0] SEG7_BASE_ADDR  = 8'hD0;
  localparam int         SEG7_NUM_DIGITS = 4;
  localparam int         SEG7_MSG_DEPTH  = 16;

  typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} seg7_state_t;

  // (base + k) mod len; a zero length never drives a real beat, so it just maps to entry 0
  function automatic logic [3:0] wrap_idx(input logic [3:0] base, input logic [1:0] k,
                                          input logic [4:0] len);
    logic [4:0] sum;
    sum = {1'b0, base} + {3'b000, k};
    if (len == 5'd0) return 4'd0;
    return 4'(sum % len);
  endfunction

endpackage

// File: rtl/seg7_tick_div.sv
// Free-running scroll tick divider: one-cycle TICK every TICK_DIV enabled cycles.
module seg7_tick_div #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  output logic TICK
);

  logic [31:0] count;

  assign TICK = EN && (count == 32'(TICK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= 32'd0;
    end else if (TICK) begin
      count <= 32'd0;
    end else if (EN) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/seg7_scroll_ctrl.sv
// Bus-master that scrolls a 16-nibble message across the four digit registers,
// writing one 4-beat burst per scroll tick once the arbiter grants the bus.
module seg7_scroll_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter logic [7:0]  BASE_ADDR = SEG7_BASE_ADDR,
  parameter int          MSG_DEPTH = SEG7_MSG_DEPTH
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       MSG_WE,
  input  logic [3:0] MSG_IDX,
  input  logic [3:0] MSG_NIBBLE,
  input  logic [4:0] MSG_LEN,
  output logic       BUS_REQ,
  input  logic       BUS_GNT,
  output logic [7:0] BUS_ADDR_OUT,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_WE_OUT,
  output logic       BUSY,
  output logic [3:0] OFFSET
);

  logic [3:0]  msg_buf [MSG_DEPTH];
  logic        tick;
  logic        pending;
  logic        consume;
  logic [4:0]  len;
  seg7_state_t state;
  logic [1:0]  beat;
  logic [1:0]  launch_beat;
  logic [7:0]  launch_addr;
  logic [7:0]  launch_data;

  assign len     = (MSG_LEN > 5'd16) ? 5'd16 : MSG_LEN;
  assign consume = (state == IDLE) && pending && (len != 5'd0);

  seg7_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .CLK  (CLK),
    .RESET(RESET),
    .EN   (ENABLE),
    .TICK (tick)
  );

  // The buffer is deliberately outside reset so a message survives a controller reset
  always_ff @(posedge CLK) begin
    if (MSG_WE) msg_buf[MSG_IDX] <= MSG_NIBBLE;
  end

  // A tick always moves the window; pending is only one deep, so extra ticks just re-set it
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending <= 1'b0;
      OFFSET  <= 4'd0;
    end else if (tick && (len != 5'd0)) begin
      pending <= 1'b1;
      OFFSET  <= (({1'b0, OFFSET} + 5'd1) >= len) ? 4'd0 : OFFSET + 4'd1;
    end else if (consume) begin
      pending <= 1'b0;
    end
  end

  // Beat to put on the bus at the next edge: advance after a written beat, hold after a stall
  always_comb begin
    launch_beat = 2'd0;
    if (state == BURST) launch_beat = BUS_WE_OUT ? beat + 2'd1 : beat;
  end

  assign launch_addr = BASE_ADDR + {6'd0, launch_beat};
  assign launch_data = {4'h0, msg_buf[wrap_idx(OFFSET, launch_beat, len)]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      beat         <= 2'd0;
      BUS_REQ      <= 1'b0;
      BUSY         <= 1'b0;
      BUS_WE_OUT   <= 1'b0;
      BUS_ADDR_OUT <= 8'h00;
      BUS_DATA_OUT <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pending && (len != 5'd0)) begin
            state   <= REQ;
            BUS_REQ <= 1'b1;
            BUSY    <= 1'b1;
          end
        end
        REQ: begin
          if (BUS_GNT) begin
            state        <= BURST;
            beat         <= 2'd0;
            BUS_WE_OUT   <= 1'b1;
            BUS_ADDR_OUT <= launch_addr;
            BUS_DATA_OUT <= launch_data;
          end
        end
        BURST: begin
          if (BUS_WE_OUT && (beat == 2'(SEG7_NUM_DIGITS - 1))) begin
            state        <= DONE;
            BUS_REQ      <= 1'b0;
            BUSY         <= 1'b0;
            BUS_WE_OUT   <= 1'b0;
            BUS_ADDR_OUT <= 8'h00;
            BUS_DATA_OUT <= 8'h00;
          end else begin
            beat         <= launch_beat;
            BUS_WE_OUT   <= BUS_GNT;
            BUS_ADDR_OUT <= launch_addr;
            BUS_DATA_OUT <= launch_data;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
